// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the three-way AXI read arbiter.
// State encodings, requester indices and address alignment helpers.
// Imported by the selector, the top and the bench.
package mem_read_arbiter_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  localparam int NUM_REQ = 3;
  localparam int REQ_UC  = 0;
  localparam int REQ_DC  = 1;
  localparam int REQ_IC  = 2;

  localparam int WORD_OFFSET_W = 2;
  localparam int LINE_OFFSET_W = 5;

  // Align a byte address down to its 32-bit word.
  function automatic logic [31:0] word_base(input logic [31:0] a);
    return {a[31:WORD_OFFSET_W], {WORD_OFFSET_W{1'b0}}};
  endfunction

  // Align a byte address down to its cache line.
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// AXI read address/data channel as seen by the arbiter and the bridge.
// master = arbiter side, slave = AXI bridge side.
// No logic, signal bundle only.
interface mem_read_arbiter_if;
  logic        ren;
  logic        arready;
  logic [31:0] raddr;
  logic [3:0]  rlen;
  logic        rready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output ren, raddr, rlen, rready,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  ren, raddr, rlen, rready,
    output arready, rvalid, rdata
  );
endinterface

// File: rtl/mem_rd_prio_sel.sv
// Fixed-priority one-hot selector: UC > DC > IC, IC forced when starved.
// Purely combinational, zero latency.
// No backpressure; callers only sample the grant when they can accept it.
module mem_rd_prio_sel
  import mem_read_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic               starve_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // Pick at most one eligible requester.
  always_comb begin
    gnt_o = '0;
    if (starve_i && elig_i[REQ_IC]) begin
      gnt_o[REQ_IC] = 1'b1;
    end else if (elig_i[REQ_UC]) begin
      gnt_o[REQ_UC] = 1'b1;
    end else if (elig_i[REQ_DC]) begin
      gnt_o[REQ_DC] = 1'b1;
    end else if (elig_i[REQ_IC]) begin
      gnt_o[REQ_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI read channel between uncached loads, DCache and ICache refills.
// Grant to address valid 1 cycle; return beats steered with 0 latency.
// Requesters hold req until served; the bridge stalls us via arready/rvalid.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int BEATS        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uc_req_i,
  input  logic [31:0] uc_addr_i,
  output logic        uc_rvalid_o,
  input  logic        dc_req_i,
  input  logic [31:0] dc_addr_i,
  output logic        dc_rvalid_o,
  output logic        dc_rlast_o,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_rvalid_o,
  output logic        ic_rlast_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  beat_idx_o,
  input  logic        wb_pending_i,
  input  logic [31:0] wb_addr_i,
  mem_read_arbiter_if.master axi
);

  localparam logic [3:0] BURST_LEN  = 4'(BEATS - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  rd_state_e          state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         rlen_q, rlen_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_sel;
  logic               starved;
  logic               last_beat;

  // Hold back data-side reads that would overtake a pending write to the same word/line.
  always_comb begin
    elig         = '0;
    elig[REQ_UC] = uc_req_i &&
                   !(wb_pending_i && (word_base(wb_addr_i) == word_base(uc_addr_i)));
    elig[REQ_DC] = dc_req_i &&
                   !(wb_pending_i && (line_base(wb_addr_i) == line_base(dc_addr_i)));
    elig[REQ_IC] = ic_req_i;
  end

  assign starved   = (starve_cnt_q == STARVE_MAX);
  assign last_beat = (beat_cnt_q == rlen_q);

  mem_rd_prio_sel u_prio_sel (
    .elig_i   (elig),
    .starve_i (starved),
    .gnt_o    (gnt_sel)
  );

  // State, grant, counters and latched burst descriptor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      rlen_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      rlen_q       <= rlen_d;
    end
  end

  // Next state: arbitrate in IDLE, wait for arready, count beats to the end of the burst.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    rlen_d       = rlen_q;
    case (state_q)
      RD_IDLE: begin
        if (|gnt_sel) begin
          state_d = RD_ADDR;
          grant_d = gnt_sel;
          if (gnt_sel[REQ_UC]) begin
            addr_d = word_base(uc_addr_i);
            rlen_d = 4'd0;
          end else if (gnt_sel[REQ_DC]) begin
            addr_d = line_base(dc_addr_i);
            rlen_d = BURST_LEN;
          end else begin
            addr_d = line_base(ic_addr_i);
            rlen_d = BURST_LEN;
          end
          // IC losing while it waits counts towards its forced win.
          if (gnt_sel[REQ_IC] || !ic_req_i) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          if (last_beat) begin
            state_d    = RD_IDLE;
            beat_cnt_d = '0;
            grant_d    = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // Outputs: AXI handshakes from state, return steering to the granted port only; forced low in reset.
  always_comb begin
    axi.ren     = 1'b0;
    axi.raddr   = '0;
    axi.rlen    = '0;
    axi.rready  = 1'b0;
    uc_rvalid_o = 1'b0;
    dc_rvalid_o = 1'b0;
    dc_rlast_o  = 1'b0;
    ic_rvalid_o = 1'b0;
    ic_rlast_o  = 1'b0;
    rdata_o     = '0;
    beat_idx_o  = '0;
    if (!rst) begin
      case (state_q)
        RD_ADDR: begin
          axi.ren   = 1'b1;
          axi.raddr = addr_q;
          axi.rlen  = rlen_q;
        end
        RD_DATA: begin
          axi.raddr  = addr_q;
          axi.rlen   = rlen_q;
          axi.rready = 1'b1;
          rdata_o    = axi.rdata;
          beat_idx_o = beat_cnt_q;
          if (axi.rvalid) begin
            uc_rvalid_o = grant_q[REQ_UC];
            dc_rvalid_o = grant_q[REQ_DC];
            dc_rlast_o  = grant_q[REQ_DC] && last_beat;
            ic_rvalid_o = grant_q[REQ_IC];
            ic_rlast_o  = grant_q[REQ_IC] && last_beat;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
Sequences the single AXI read channel and shares it between three requesters: the uncached data load (UC, 1 word), the DCache line refill (DC, 8-word burst) and the ICache line refill (IC, 8-word burst). It sits between the caches and the AXI master bridge. It owns the arbitration, the address phase, the beat counting and the per-requester return steering. It also holds back any data-side read that hits a line with a write still pending in the write path.

Parameters:
BEATS, 8, words per cache-line burst (power of two, 2..16)
STARVE_LIMIT, 4, consecutive lost arbitrations after which IC gets forced priority (1..15)

Ports:
clk  in  1  clock, single domain
rst  in  1  synchronous, active-high reset
uc_req_i  in  1  uncached load request, held until uc_rvalid_o
uc_addr_i  in  32  uncached load byte address
uc_rvalid_o  out  1  UC data valid, 1 cycle
dc_req_i  in  1  DCache refill request, held until dc_rlast_o
dc_addr_i  in  32  DCache miss address
dc_rvalid_o  out  1  DC beat valid
dc_rlast_o  out  1  DC final beat
ic_req_i  in  1  ICache refill request, held until ic_rlast_o
ic_addr_i  in  32  ICache miss address
ic_rvalid_o  out  1  IC beat valid
ic_rlast_o  out  1  IC final beat
rdata_o  out  32  shared return word, valid with any *_rvalid_o
beat_idx_o  out  4  word index within line of current beat
wb_pending_i  in  1  write path holds an unretired write
wb_addr_i  in  32  address of that pending write
axi_ren_o  out  1  address valid
axi_arready_i  in  1  address accepted
axi_raddr_o  out  32  read address
axi_rlen_o  out  4  burst length minus one
axi_rready_o  out  1  ready for data
axi_rvalid_i  in  1  data beat valid
axi_rdata_i  in  32  data beat

Behaviour:
- States: IDLE, ADDR, DATA. Reset puts the block in IDLE. Reset also clears grant, beat_cnt and starve_cnt, and drives every output to 0. This holds mid-burst too: rready drops at once and beats still in flight are dropped, not steered.
- Hazard mask:
  - UC is eligible only if !(wb_pending_i && wb_addr_i[31:2]==uc_addr_i[31:2]).
  - DC is eligible only if !(wb_pending_i && wb_addr_i[31:5]==dc_addr_i[31:5]).
  - IC is never masked.
- Arbitration happens in IDLE only, among eligible requests:
  - Normal priority is UC > DC > IC.
  - If starve_cnt==STARVE_LIMIT and IC requests, IC wins.
  - Grant is registered one-hot. Entering ADDR takes 1 cycle.
- Starvation counter:
  - Increments on each grant to UC or DC while ic_req_i is high, saturating at STARVE_LIMIT.
  - Clears on an IC grant, or when a grant is issued while ic_req_i is low.
- Address latching at grant:
  - UC: {addr[31:2],2'b00}, rlen 0.
  - DC/IC: {addr[31:5],5'b0}, rlen BEATS-1.
  - The latched address and length are held through the burst. Requester address changes after grant are ignored.
- ADDR state: axi_ren_o=1 until the cycle axi_arready_i=1, then go to DATA. axi_rready_o=0.
- DATA state:
  - axi_rready_o=1.
  - Each axi_rvalid_i beat is steered combinationally, with 0 latency, to the granted port's rvalid. rdata_o=axi_rdata_i, beat_idx_o=beat_cnt.
  - beat_cnt increments per beat.
  - The last beat (beat_cnt==rlen) asserts the granted port's rlast (UC: rvalid only), returns to IDLE and clears beat_cnt.
- Back-to-back: at least 1 IDLE cycle between bursts. Arbitration re-evaluates in that cycle, so a request dropped before then is never serviced.
- Outputs of non-granted ports stay 0. Outside DATA, rdata_o and beat_idx_o are 0.
- axi_rvalid_i outside DATA is ignored.
- A requester dropping req mid-burst does not abort the burst; remaining beats are still counted.
- Simultaneous UC+DC+IC in IDLE with starve_cnt<LIMIT: UC granted, starve_cnt+1.

Decomposition:
- Shared package/defines header holds:
  - state encodings RD_IDLE/RD_ADDR/RD_DATA;
  - requester indices REQ_UC/REQ_DC/REQ_IC;
  - LINE_OFFSET_W=5.
- One natural sub-module: mem_rd_prio_sel. It is combinational: eligible vector plus starve flag in, one-hot grant out. It is unit-testable alone.
- The FSM, counters and steering stay in the top module.

Test Plan:
- Lone IC req at 0x1FC0_0024, arready same cycle as ren, 8 beats 0xA0..0xA7 → axi_raddr_o=0x1FC0_0020, rlen=7, ic_rvalid_o ×8 with beat_idx 0..7, ic_rlast_o on 0xA7, then IDLE.
- UC, DC, IC all request in the same IDLE cycle → grant order UC (rlen 0), DC, then IC, with one IDLE gap between each.
- DC requests keep winning against a held IC → exactly 4 DC grants, then the IC grant regardless of DC; starve_cnt then 0.
- wb_pending_i=1, wb_addr_i=0x8000_1004, dc_addr_i=0x8000_1010, IC idle → no grant. Drop wb_pending_i → DC granted next IDLE cycle.
- UC granted, axi_arready_i held low for 5 cycles → axi_ren_o stays 1 with a stable address and no rvalid outputs. Then arready high, one beat 0xDEAD_BEEF → uc_rvalid_o with rdata_o=0xDEAD_BEEF.
- rst asserted after beat 3 of a DC burst → next cycle all outputs 0 and state IDLE. Further axi_rvalid_i beats produce no dc_rvalid_o.
